// File: rtl/fpnew_sdotp_result_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpnew_sdotp_result_packer_if
//  Description : Handshake bundle between the sdotp unit result side, the
//                result packer and the FPU result arbiter. The master view
//                belongs to the environment that produces results and sinks
//                packed words. The slave view belongs to the packer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpnew_sdotp_result_packer_if #(
   parameter int unsigned LaneWidth = 64,
   parameter int unsigned DstWidth  = 32,
   parameter type         TagType   = logic
);
   // Result beats arriving from the sdotp unit
   logic [DstWidth-1:0]  in_result_i;
   logic [4:0]           in_status_i;
   logic                 in_ext_bit_i;
   TagType               in_tag_i;
   logic                 in_pack_i;
   logic                 in_valid_i;
   logic                 in_ready_o;

   // Pipeline control
   logic                 flush_i;

   // Packed words going to the result arbiter
   logic [LaneWidth-1:0] result_o;
   logic [4:0]           status_o;
   logic                 extension_bit_o;
   TagType               tag_o;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic                 busy_o;

   // Environment side: drives beats, flush and downstream ready
   modport master (
      output in_result_i, in_status_i, in_ext_bit_i, in_tag_i, in_pack_i,
      output in_valid_i, flush_i, out_ready_i,
      input  in_ready_o, result_o, status_o, extension_bit_o, tag_o,
      input  out_valid_o, busy_o
   );

   // Packer side
   modport slave (
      input  in_result_i, in_status_i, in_ext_bit_i, in_tag_i, in_pack_i,
      input  in_valid_i, flush_i, out_ready_i,
      output in_ready_o, result_o, status_o, extension_bit_o, tag_o,
      output out_valid_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/fpnew_sdotp_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fpnew_sdotp_result_packer
//  Description : Collects DstWidth-wide sdotp results and re-packs them into
//                LaneWidth-wide words. Unwritten upper slots stay NaN-boxed
//                (all ones); status and extension flags are ORed over every
//                beat of a word; the tag of the closing beat travels with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpnew_sdotp_result_packer #(
   parameter int unsigned LaneWidth = 64,
   parameter int unsigned DstWidth  = 32,
   parameter type         TagType   = logic
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   fpnew_sdotp_result_packer_if.slave    bus
);

   // Number of result slots in one packed word and the slot counter width.
   // A single-slot configuration still keeps a 1-bit counter that never moves.
   localparam int              c_num_slots = int'(LaneWidth / DstWidth);
   localparam int              c_cnt_w     = (c_num_slots > 1) ? $clog2(c_num_slots) : 1;
   localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(c_num_slots - 1);

   // FILL gathers beats; HOLD presents a finished word until it is taken.
   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Registered state
   state_e               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [LaneWidth-1:0] r_word;
   logic [4:0]           r_status;
   logic                 r_ext;
   TagType               r_tag;

   // Next-state values and handshake terms
   state_e               w_state_d;
   logic [c_cnt_w-1:0]   w_cnt_d;
   logic [LaneWidth-1:0] w_word_d;
   logic [4:0]           w_status_d;
   logic                 w_ext_d;
   TagType               w_tag_d;

   logic                 w_hold;
   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_release;
   logic                 w_close;

   // Word/flag bases the incoming beat is merged into, plus the merged word
   logic [LaneWidth-1:0] w_base_word;
   logic [4:0]           w_base_status;
   logic                 w_base_ext;
   logic [LaneWidth-1:0] w_filled_word;

   // Handshake decode. Ready only depends on registered state and the
   // downstream ready, so no combinational path from in_valid_i exists.
   always_comb begin
      w_hold     = (r_state == ST_HOLD);
      w_in_ready = !w_hold || bus.out_ready_i;
      w_accept   = bus.in_valid_i && w_in_ready;
      w_release  = w_hold && bus.out_ready_i;
      // Last slot forces a close regardless of in_pack_i
      w_close    = !bus.in_pack_i || (r_cnt == c_last_slot);
   end

   // Slot merge. A beat accepted while a word is held (which implies the
   // held word is released in the same cycle) starts a fresh NaN-boxed word
   // with clean flags; the counter is already zero in HOLD.
   always_comb begin
      w_base_word   = w_hold ? {LaneWidth{1'b1}} : r_word;
      w_base_status = w_hold ? 5'b0 : r_status;
      w_base_ext    = w_hold ? 1'b0 : r_ext;
      w_filled_word = w_base_word;
      for (int s = 0; s < c_num_slots; s++) begin
         if (r_cnt == c_cnt_w'(s)) begin
            w_filled_word[s*DstWidth +: DstWidth] = bus.in_result_i;
         end
      end
   end

   // Next-state logic: flush beats everything, then accept, then a plain release.
   always_comb begin
      w_state_d  = r_state;
      w_cnt_d    = r_cnt;
      w_word_d   = r_word;
      w_status_d = r_status;
      w_ext_d    = r_ext;
      w_tag_d    = r_tag;

      if (bus.flush_i) begin
         w_state_d  = ST_FILL;
         w_cnt_d    = '0;
         w_word_d   = {LaneWidth{1'b1}};
         w_status_d = 5'b0;
         w_ext_d    = 1'b0;
      end else if (w_accept) begin
         w_word_d   = w_filled_word;
         w_status_d = w_base_status | bus.in_status_i;
         w_ext_d    = w_base_ext | bus.in_ext_bit_i;
         if (w_close) begin
            w_state_d = ST_HOLD;
            w_cnt_d   = '0;
            w_tag_d   = bus.in_tag_i;
         end else begin
            w_state_d = ST_FILL;
            w_cnt_d   = r_cnt + c_cnt_w'(1);
         end
      end else if (w_release) begin
         w_state_d  = ST_FILL;
         w_word_d   = {LaneWidth{1'b1}};
         w_status_d = 5'b0;
         w_ext_d    = 1'b0;
      end
   end

   // State register; reset discards any partial word immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_FILL;
         r_cnt    <= '0;
         r_word   <= {LaneWidth{1'b1}};
         r_status <= 5'b0;
         r_ext    <= 1'b0;
         r_tag    <= TagType'('0);
      end else begin
         r_state  <= w_state_d;
         r_cnt    <= w_cnt_d;
         r_word   <= w_word_d;
         r_status <= w_status_d;
         r_ext    <= w_ext_d;
         r_tag    <= w_tag_d;
      end
   end

   // Outputs come straight from registered state.
   always_comb begin
      bus.in_ready_o      = w_in_ready;
      bus.result_o        = r_word;
      bus.status_o        = r_status;
      bus.extension_bit_o = r_ext;
      bus.tag_o           = r_tag;
      bus.out_valid_o     = (r_state == ST_HOLD);
      bus.busy_o          = (r_state == ST_HOLD) || (r_cnt != '0);
   end

endmodule
`default_nettype wire

// File: tb/tb_fpnew_sdotp_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpnew_sdotp_result_packer
//  Description : Scoreboard bench for the sdotp result packer. A queue-based
//                reference model predicts packed words; a negedge monitor
//                compares handshake state and every released word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpnew_sdotp_result_packer;

   localparam int LW = 64;
   localparam int DW = 32;
   localparam int NS = LW / DW;

   typedef logic [3:0] tag_t;

   typedef struct {
      logic [LW-1:0] word;
      logic [4:0]    st;
      logic          ext;
      tag_t          tag;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fpnew_sdotp_result_packer_if #(.LaneWidth(LW), .DstWidth(DW), .TagType(tag_t)) bus ();

   fpnew_sdotp_result_packer #(
      .LaneWidth(LW),
      .DstWidth (DW),
      .TagType  (tag_t)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: beats of the word being built, merged flags, pending flag
   exp_t          exp_q[$];
   logic [DW-1:0] m_beats[$];
   logic [4:0]    m_st  = 5'b0;
   logic          m_ext = 1'b0;
   bit            m_ov  = 1'b0;
   exp_t          mon_e;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, expv, $time);
      end
   endtask

   task automatic model_clear();
      m_beats.delete();
      m_st  = 5'b0;
      m_ext = 1'b0;
      m_ov  = 1'b0;
   endtask

   // One clock of stimulus; the model advances on the same edge as the DUT.
   task automatic cyc(input logic v, input logic [DW-1:0] res, input logic [4:0] st,
                      input logic ext, input tag_t tg, input logic pk,
                      input logic ordy, input logic fl);
      logic [LW-1:0] w;
      exp_t          e;
      bit            acc;
      bus.in_valid_i   = v;
      bus.in_result_i  = res;
      bus.in_status_i  = st;
      bus.in_ext_bit_i = ext;
      bus.in_tag_i     = tg;
      bus.in_pack_i    = pk;
      bus.out_ready_i  = ordy;
      bus.flush_i      = fl;
      @(posedge clk);
      acc = v && (!m_ov || ordy);
      if (fl) begin
         if (m_ov) void'(exp_q.pop_back());
         model_clear();
      end else begin
         if (m_ov && ordy) m_ov = 1'b0;
         if (acc) begin
            m_beats.push_back(res);
            m_st  = m_st | st;
            m_ext = m_ext | ext;
            if (!pk || m_beats.size() == NS) begin
               w = '1;
               foreach (m_beats[i]) w[i*DW +: DW] = m_beats[i];
               e.word = w;
               e.st   = m_st;
               e.ext  = m_ext;
               e.tag  = tg;
               exp_q.push_back(e);
               model_clear();
               m_ov = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b0, '0, 5'b0, 1'b0, 4'h0, 1'b0, ordy, 1'b0);
   endtask

   // Monitor: handshake state each cycle, word contents on every release
   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", LW'(bus.out_valid_o), LW'(m_ov));
         chk("busy", LW'(bus.busy_o), LW'(m_ov || m_beats.size() != 0));
         chk("in_ready", LW'(bus.in_ready_o), LW'(!m_ov || bus.out_ready_i));
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%h required=none", bus.result_o);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word", bus.result_o, mon_e.word);
               chk("status", LW'(bus.status_o), LW'(mon_e.st));
               chk("ext", LW'(bus.extension_bit_o), LW'(mon_e.ext));
               chk("tag", LW'(bus.tag_o), LW'(mon_e.tag));
            end
         end
      end
   end

   initial begin
      logic fl;
      bus.in_valid_i   = 1'b0;
      bus.in_result_i  = '0;
      bus.in_status_i  = '0;
      bus.in_ext_bit_i = 1'b0;
      bus.in_tag_i     = '0;
      bus.in_pack_i    = 1'b0;
      bus.out_ready_i  = 1'b0;
      bus.flush_i      = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", LW'(bus.out_valid_o), '0);
      chk("rst_busy", LW'(bus.busy_o), '0);
      chk("rst_word", bus.result_o, {LW{1'b1}});
      chk("rst_status", LW'(bus.status_o), '0);
      chk("rst_ext", LW'(bus.extension_bit_o), '0);
      chk("rst_tag", LW'(bus.tag_o), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single close
      cyc(1'b1, 32'h3F800000, 5'b0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0);
      chk("single_word", bus.result_o, 64'hFFFFFFFF_3F800000);
      chk("single_busy", LW'(bus.busy_o), 64'd1);
      idle(1'b1);

      // Pair with flag merge
      cyc(1'b1, 32'h40000000, 5'b00001, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 32'h40400000, 5'b00100, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
      chk("pair_word", bus.result_o, 64'h40400000_40000000);
      chk("pair_status", LW'(bus.status_o), 64'h5);
      chk("pair_tag", LW'(bus.tag_o), 64'h7);
      idle(1'b1);

      // Forced close at the last slot
      cyc(1'b1, 32'hA0A0A0A0, 5'b0, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 32'hB1B1B1B1, 5'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0);
      chk("forced_word", bus.result_o, 64'hB1B1B1B1_A0A0A0A0);
      cyc(1'b1, 32'hC2C2C2C2, 5'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0);
      chk("forced_ov", LW'(bus.out_valid_o), 64'd0);
      chk("forced_busy", LW'(bus.busy_o), 64'd1);
      cyc(1'b1, 32'hD3D3D3D3, 5'b0, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0);
      chk("forced_next", bus.result_o, 64'hD3D3D3D3_C2C2C2C2);

      // Backpressure then back-to-back word without flag merge
      cyc(1'b1, 32'h11111111, 5'b00011, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 32'h22222222, 5'b01000, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
         chk("bp_in_ready", LW'(bus.in_ready_o), 64'd0);
         chk("bp_stable", bus.result_o, 64'hFFFFFFFF_11111111);
      end
      cyc(1'b1, 32'h33333333, 5'b10000, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0);
      chk("b2b_ov", LW'(bus.out_valid_o), 64'd1);
      chk("b2b_status", LW'(bus.status_o), 64'h10);
      chk("b2b_word", bus.result_o, 64'hFFFFFFFF_33333333);
      idle(1'b1);

      // Flush mid-word with a simultaneous beat
      cyc(1'b1, 32'h44444444, 5'b00010, 1'b0, 4'h8, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 32'h55555555, 5'b00010, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1);
      chk("flush_busy", LW'(bus.busy_o), 64'd0);
      chk("flush_ov", LW'(bus.out_valid_o), 64'd0);
      cyc(1'b1, 32'h12345678, 5'b0, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0);
      chk("flush_next", bus.result_o, 64'hFFFFFFFF_12345678);
      chk("flush_status", LW'(bus.status_o), 64'h0);

      // Asynchronous reset with a word pending
      cyc(1'b1, 32'h66666666, 5'b00001, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ov", LW'(bus.out_valid_o), 64'd0);
      chk("arst_busy", LW'(bus.busy_o), 64'd0);
      chk("arst_word", bus.result_o, {LW{1'b1}});
      model_clear();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         fl = ($urandom_range(0, 99) < 3);
         cyc(($urandom_range(0, 99) < 70), $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), tag_t'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)),
             fl ? 1'b0 : ($urandom_range(0, 99) < 60), fl);
      end

      // Drain
      repeat (4) idle(1'b1);
      chk("drain_empty", LW'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
